// File: rtl/sar_search.sv
// sar_search: successive-approximation search that drives comparator B
// and recovers the unknown A operand from the eq/gt/lt flags.
module sar_search #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             cmp_eq,
   input  logic             cmp_gt,
   input  logic             cmp_lt,
   output logic [WIDTH-1:0] guess,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             err
);

   typedef enum logic [1:0] {
      IDLE,
      TRY,
      DONE
   } state_t;

   localparam logic [WIDTH-1:0] MSB = WIDTH'(1) << (WIDTH - 1);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] guess_q, guess_d;
   logic [WIDTH-1:0] bit_q, bit_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             err_q, err_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   // bit_q is a one-hot marker of the bit under trial; bit 0 set means idx==0
   logic [WIDTH-1:0] nxt_bit;
   logic             last;

   assign nxt_bit = bit_q >> 1;
   assign last    = bit_q[0];

   // state and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         guess_q  <= '0;
         bit_q    <= MSB;
         result_q <= '0;
         err_q    <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         guess_q  <= guess_d;
         bit_q    <= bit_d;
         result_q <= result_d;
         err_q    <= err_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   // next-state: one trial per TRY cycle, flags consumed combinationally
   always_comb begin
      state_d  = state_q;
      guess_d  = guess_q;
      bit_d    = bit_q;
      result_d = result_q;
      err_d    = err_q;
      unique case (state_q)
         IDLE: begin
            guess_d = '0;
            if (start) begin
               state_d = TRY;
               guess_d = MSB;
               bit_d   = MSB;
               err_d   = 1'b0;
            end
         end
         TRY: begin
            case ({cmp_eq, cmp_gt, cmp_lt})
               3'b100: begin
                  result_d = guess_q;
                  guess_d  = '0;
                  state_d  = DONE;
               end
               3'b010: begin
                  if (last) begin
                     err_d    = 1'b1;
                     result_d = guess_q;
                     guess_d  = '0;
                     state_d  = DONE;
                  end else begin
                     guess_d = guess_q | nxt_bit;
                     bit_d   = nxt_bit;
                  end
               end
               3'b001: begin
                  if (last) begin
                     result_d = guess_q & ~bit_q;
                     guess_d  = '0;
                     state_d  = DONE;
                  end else begin
                     guess_d = (guess_q & ~bit_q) | nxt_bit;
                     bit_d   = nxt_bit;
                  end
               end
               default: begin
                  err_d    = 1'b1;
                  result_d = guess_q;
                  guess_d  = '0;
                  state_d  = DONE;
               end
            endcase
         end
         DONE: begin
            guess_d = '0;
            state_d = IDLE;
         end
         default: begin
            guess_d = '0;
            state_d = IDLE;
         end
      endcase
   end

   // status flags are registered views of the next state
   always_comb begin
      busy_d = (state_d == TRY);
      done_d = (state_d == DONE);
   end

   assign guess  = guess_q;
   assign busy   = busy_q;
   assign done   = done_q;
   assign result = result_q;
   assign err    = err_q;

endmodule

// File: tb/tb_sar_search.sv
// tb_sar_search: randomized and directed scoreboard bench for sar_search
// with a behavioural comparator model and a flag-override hook.
module tb_sar_search;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic [W-1:0] target = '0;
   logic         ovr_en = 1'b0;
   logic [2:0]   ovr_f = 3'b000;
   logic         cmp_eq, cmp_gt, cmp_lt;
   logic [W-1:0] guess, result;
   logic         busy, done, err;

   int cyc = 0;
   int errors = 0;
   int checks = 0;

   typedef struct packed {
      logic [W-1:0]         res;
      logic                 err;
      int                   k;
      int                   issue;
      logic [W-1:0][W-1:0]  tr;
   } exp_t;

   exp_t q[$];

   sar_search #(.WIDTH(W)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .cmp_eq (cmp_eq),
      .cmp_gt (cmp_gt),
      .cmp_lt (cmp_lt),
      .guess  (guess),
      .busy   (busy),
      .done   (done),
      .result (result),
      .err    (err)
   );

   assign cmp_eq = ovr_en ? ovr_f[2] : (target == guess);
   assign cmp_gt = ovr_en ? ovr_f[1] : (target > guess);
   assign cmp_lt = ovr_en ? ovr_f[0] : (target < guess);

   always #5 clk = ~clk;

   initial forever begin
      @(negedge clk);
      cyc <= cyc + 1;
   end

   task automatic chk(input string n, input int a, input int x);
      checks++;
      if (a != x) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", n, a, x, cyc);
      end
   endtask

   // Binary search over the value range: each trial halves the step;
   // flags come from the target unless trial ot is overridden.
   function automatic exp_t model(input int t, input int ot,
                                  input logic [2:0] of, input int issue);
      exp_t       e;
      int         g;
      int         step;
      logic [2:0] f;
      bit         fin;
      e = '0;
      e.issue = issue;
      g = 1 << (W - 1);
      step = g;
      fin = 0;
      for (int j = 1; j <= W && !fin; j++) begin
         e.tr[j-1] = W'(g);
         e.k = j;
         if (j == ot) f = of;
         else f = {t == g, t > g, t < g};
         if (f == 3'b100) begin
            e.res = W'(g);
            fin = 1;
         end else if (f == 3'b010 && step > 1) begin
            g = g + step / 2;
         end else if (f == 3'b001 && step > 1) begin
            g = g - step + step / 2;
         end else if (f == 3'b001) begin
            e.res = W'(g - 1);
            fin = 1;
         end else begin
            e.err = 1'b1;
            e.res = W'(g);
            fin = 1;
         end
         step = step / 2;
      end
      return e;
   endfunction

   // monitor: collect the guess trace, compare on every done pulse
   initial begin
      logic [W-1:0] obs[$];
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            obs.delete();
         end else if (busy) begin
            obs.push_back(guess);
         end else if (done) begin
            if (q.size() == 0) begin
               chk("unexpected_done", int'(done), 0);
            end else begin
               e = q.pop_front();
               chk("trials", obs.size(), e.k);
               chk("result", int'(result), int'(e.res));
               chk("err", int'(err), int'(e.err));
               chk("latency", cyc - e.issue, e.k + 1);
               for (int i = 0; i < e.k && i < obs.size(); i++)
                  chk("guess", int'(obs[i]), int'(e.tr[i]));
            end
            obs.delete();
         end
      end
   end

   task automatic run(input int t, input int ot,
                      input logic [2:0] of, input bit again);
      bit fin;
      fin = 0;
      @(negedge clk);
      target = W'(t);
      start = 1'b1;
      q.push_back(model(t, ot, of, cyc));
      for (int j = 1; j <= W + 2 && !fin; j++) begin
         @(negedge clk);
         start = again && (j == 2);
         ovr_en = (j == ot);
         ovr_f = of;
         if (done) fin = 1;
      end
      start = 1'b0;
      ovr_en = 1'b0;
      chk("done_seen", int'(fin), 1);
   endtask

   task automatic run_held(input int t1, input int t2);
      int n;
      @(negedge clk);
      target = W'(t1);
      start = 1'b1;
      q.push_back(model(t1, 0, 3'b000, cyc));
      n = 0;
      while (!done && n < W + 3) begin
         @(negedge clk);
         n++;
      end
      chk("held_done1", int'(done), 1);
      target = W'(t2);
      q.push_back(model(t2, 0, 3'b000, cyc + 1));
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!done && n < W + 4);
      chk("held_done2", int'(done), 1);
      start = 1'b0;
   endtask

   task automatic run_reset(input int t);
      @(negedge clk);
      target = W'(t);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("busy_trial3", int'(busy), 1);
      chk("guess_trial3", int'(guess), 6);
      rst_n = 1'b0;
      #1;
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_guess", int'(guess), 0);
      chk("rst_result", int'(result), 0);
      chk("rst_err", int'(err), 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int t, ot;
      logic [2:0] of;
      bit again;
      repeat (2) @(negedge clk);
      chk("reset_busy", int'(busy), 0);
      chk("reset_done", int'(done), 0);
      chk("reset_guess", int'(guess), 0);
      chk("reset_result", int'(result), 0);
      chk("reset_err", int'(err), 0);
      rst_n = 1'b1;
      @(negedge clk);

      run(11, 0, 3'b000, 0);
      run(8, 0, 3'b000, 0);
      run(0, 0, 3'b000, 0);
      run(15, 0, 3'b000, 0);
      run(13, 2, 3'b000, 0);
      run(11, 0, 3'b000, 1);
      run(9, 0, 3'b000, 0);
      run_reset(5);
      run(6, 0, 3'b000, 0);
      run_held(3, 12);
      run(1, 4, 3'b010, 0);
      run(7, 1, 3'b111, 0);

      for (int i = 0; i < 40; i++) begin
         t = $urandom_range(0, 15);
         ot = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
         of = 3'($urandom_range(0, 7));
         again = 1'($urandom_range(0, 1));
         run(t, ot, of, again);
      end

      repeat (3) @(negedge clk);
      chk("queue_empty", q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
